// File: rtl/deco_seq_if.sv
// Handshake bus between a 3-bit code producer and the sequenced decoder.
// The producer drives in_valid/in_code; the decoder returns in_ready, the one-hot word and its fill level.
interface deco_seq_if #(
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic [2:0]               in_code;
    logic                     in_ready;
    logic [7:0]               y;
    logic                     y_valid;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output in_valid, in_code,
        input  in_ready, y, y_valid, level
    );

    modport slave (
        input  in_valid, in_code,
        output in_ready, y, y_valid, level
    );
endinterface

// File: rtl/deco_seq.sv
// FIFO-buffered 3-to-8 decoder: each code is driven one-hot for HOLD cycles, first word one edge after the push.
// Backpressure: in_ready = !full (and low in reset); a full FIFO refuses pushes even on an edge that pops.
module deco_seq #(
    parameter int HOLD  = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    deco_seq_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      timer_q, timer_d;
    logic [7:0]      y_q, y_d;
    logic            yv_q, yv_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [2:0]      mem_q [DEPTH];

    logic            full;
    logic            push;
    logic            pop;
    logic [2:0]      head;

    assign full         = (level_q == LW'(DEPTH));
    assign bus.in_ready = !rst && !full;
    assign push         = bus.in_valid && bus.in_ready;
    assign head         = mem_q[rd_ptr_q];

    assign bus.y        = y_q;
    assign bus.y_valid  = yv_q;
    assign bus.level    = level_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        y_d     = y_q;
        yv_d    = yv_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    y_d     = 8'd1 << head;
                    yv_d    = 1'b1;
                    timer_d = 8'(HOLD - 1);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (timer_q != 8'd0) begin
                    timer_d = timer_q - 8'd1;
                end else if (level_q != '0) begin
                    // Chain straight into the next word so strobes stay gap-free.
                    pop     = 1'b1;
                    y_d     = 8'd1 << head;
                    timer_d = 8'(HOLD - 1);
                end else begin
                    y_d     = 8'h00;
                    yv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = 8'h00;
                yv_d    = 1'b0;
                timer_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= 8'd0;
            y_q      <= 8'h00;
            yv_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: level and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_code;
        end
    end
endmodule

// File: tb/tb_deco_seq.sv
// Directed bench for deco_seq: a HOLD=4 instance and a HOLD=1 instance, each with an in-order code scoreboard.
module tb_deco_seq;
    localparam int HA = 4;
    localparam int HB = 1;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_seen_a = 1'b1;
    logic rst_seen_b = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [2:0] q_a[$];
    logic [2:0] q_b[$];

    deco_seq_if #(.DEPTH(DEPTH)) a_if();
    deco_seq_if #(.DEPTH(DEPTH)) b_if();

    deco_seq #(.HOLD(HA), .DEPTH(DEPTH)) dut_a (.clk(clk), .rst(rst_a), .bus(a_if.slave));
    deco_seq #(.HOLD(HB), .DEPTH(DEPTH)) dut_b (.clk(clk), .rst(rst_b), .bus(b_if.slave));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rst_seen_a <= rst_a;
        rst_seen_b <= rst_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_a(input bit v, input logic [2:0] c, output bit acc);
        a_if.in_valid = v;
        a_if.in_code  = c;
        acc = v && (a_if.in_ready === 1'b1);
        if (acc) q_a.push_back(c);
    endtask

    task automatic drive_b(input bit v, input logic [2:0] c, output bit acc);
        b_if.in_valid = v;
        b_if.in_code  = c;
        acc = v && (b_if.in_ready === 1'b1);
        if (acc) q_b.push_back(c);
    endtask

    task automatic drain_a();
        int n = 0;
        while ((a_if.y_valid !== 1'b0 || a_if.level !== '0) && n < 80) begin
            tick();
            n++;
        end
        chk("a_drain_in_time", 32'(n < 80), 1);
        tick();
        chk("a_all_codes_shown", q_a.size(), 0);
    endtask

    // Scoreboard monitor, instance A: every word must match the next queued code for exactly HA cycles.
    initial begin
        int rem = 0;
        logic [7:0] cur = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_seen_a) begin
                q_a.delete();
                rem = 0;
                chk("a_rst_y", a_if.y, 8'h00);
            end else if (a_if.y_valid === 1'b1) begin
                if (rem == 0) begin
                    if (q_a.size() == 0) begin
                        chk("a_unexpected_word", a_if.y, 8'h00);
                        rem = 1;
                    end else begin
                        cur = 8'd1 << q_a.pop_front();
                        rem = HA;
                        chk("a_new_word", a_if.y, cur);
                    end
                end else begin
                    chk("a_held_word", a_if.y, cur);
                end
                rem--;
            end else begin
                chk("a_idle_y", a_if.y, 8'h00);
                chk("a_word_cut_short", rem, 0);
                rem = 0;
            end
        end
    end

    initial begin
        int rem = 0;
        logic [7:0] cur = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_seen_b) begin
                q_b.delete();
                rem = 0;
                chk("b_rst_y", b_if.y, 8'h00);
            end else if (b_if.y_valid === 1'b1) begin
                if (rem == 0) begin
                    if (q_b.size() == 0) begin
                        chk("b_unexpected_word", b_if.y, 8'h00);
                        rem = 1;
                    end else begin
                        cur = 8'd1 << q_b.pop_front();
                        rem = HB;
                        chk("b_new_word", b_if.y, cur);
                    end
                end else begin
                    chk("b_held_word", b_if.y, cur);
                end
                rem--;
            end else begin
                chk("b_idle_y", b_if.y, 8'h00);
                chk("b_word_cut_short", rem, 0);
                rem = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bit acc;
        logic [7:0] bb[3];
        logic [2:0] fc[6];
        int idx;
        int cyc;

        bb[0] = 8'h01; bb[1] = 8'h80; bb[2] = 8'h04;
        fc[0] = 3'd1; fc[1] = 3'd2; fc[2] = 3'd3; fc[3] = 3'd4; fc[4] = 3'd5; fc[5] = 3'd6;

        // Reset with a push presented: it must be ignored.
        a_if.in_valid = 1'b1; a_if.in_code = 3'd3;
        b_if.in_valid = 1'b1; b_if.in_code = 3'd3;
        repeat (2) begin
            tick();
            chk("rst_in_ready", a_if.in_ready, 0);
            chk("rst_y", a_if.y, 8'h00);
            chk("rst_y_valid", a_if.y_valid, 0);
            chk("rst_level", a_if.level, 0);
            chk("rst_b_level", b_if.level, 0);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        a_if.in_valid = 1'b0; b_if.in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", a_if.in_ready, 1);
        chk("post_rst_b_in_ready", b_if.in_ready, 1);
        repeat (3) begin
            tick();
            chk("post_rst_no_word", a_if.y_valid, 0);
            chk("post_rst_level", a_if.level, 0);
        end

        // Single code 5, HOLD=4.
        drive_a(1, 3'd5, acc);
        tick();
        chk("single_level_after_push", a_if.level, 1);
        chk("single_not_yet", a_if.y, 8'h00);
        drive_a(0, 3'd0, acc);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("single_y", a_if.y, 8'h20);
            chk("single_y_valid", a_if.y_valid, 1);
        end
        tick();
        chk("single_removed_y", a_if.y, 8'h00);
        chk("single_removed_vld", a_if.y_valid, 0);
        chk("single_level_zero", a_if.level, 0);
        tick();

        // Back-to-back 0,7,2 with no idle gap.
        drive_a(1, 3'd0, acc);
        tick();
        chk("b2b_e0_y", a_if.y, 8'h00);
        drive_a(1, 3'd7, acc);
        tick();
        chk("b2b_y", a_if.y, bb[0]);
        drive_a(1, 3'd2, acc);
        tick();
        chk("b2b_y", a_if.y, bb[0]);
        drive_a(0, 3'd0, acc);
        for (int n = 3; n <= 12; n++) begin
            tick();
            chk("b2b_y", a_if.y, bb[(n - 1) / 4]);
        end
        tick();
        chk("b2b_end_y", a_if.y, 8'h00);
        drain_a();

        // Full FIFO: in_valid held high with codes 1..6.
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 40) begin
            drive_a(1, fc[idx], acc);
            tick();
            cyc++;
            if (acc) idx++;
            chk("full_level_bound", 32'(a_if.level <= DEPTH), 1);
            if (cyc == 5) begin
                chk("full_level_4", a_if.level, 4);
                chk("full_in_ready_low", a_if.in_ready, 0);
            end
            if (cyc == 6) chk("full_refused_on_pop", a_if.level, 3);
        end
        drive_a(0, 3'd0, acc);
        chk("full_all_accepted", idx, 6);
        drain_a();

        // Mid-DRIVE reset with two codes queued.
        drive_a(1, 3'd6, acc);
        tick();
        drive_a(1, 3'd1, acc);
        tick();
        chk("mid_drive1_y", a_if.y, 8'h40);
        drive_a(1, 3'd2, acc);
        tick();
        chk("mid_drive2_y", a_if.y, 8'h40);
        chk("mid_queued", a_if.level, 2);
        drive_a(0, 3'd0, acc);
        rst_a = 1'b1;
        tick();
        chk("mid_rst_y", a_if.y, 8'h00);
        chk("mid_rst_vld", a_if.y_valid, 0);
        chk("mid_rst_level", a_if.level, 0);
        rst_a = 1'b0;
        repeat (2) begin
            tick();
            chk("mid_no_stale_word", a_if.y_valid, 0);
        end
        drive_a(1, 3'd3, acc);
        tick();
        drive_a(0, 3'd0, acc);
        tick();
        chk("mid_new_push_y", a_if.y, 8'h08);
        drain_a();

        // HOLD=1: codes 1 then 6.
        drive_b(1, 3'd1, acc);
        tick();
        drive_b(1, 3'd6, acc);
        tick();
        chk("h1_first", b_if.y, 8'h02);
        drive_b(0, 3'd0, acc);
        tick();
        chk("h1_second", b_if.y, 8'h40);
        tick();
        chk("h1_idle", b_if.y, 8'h00);
        chk("h1_idle_vld", b_if.y_valid, 0);
        chk("h1_all_shown", q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
